cvp_seq: RTL



---
 rtl/cvp_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cvp_seq.sv
// CVP fetch/execute sequencer: scalar imm loads, jump, NOP, LANES-wide VLD/VST. Optional: SINGLE_STEP_EN.
// Latency: 3 cycles for scalar/jump/NOP and 3+LANES for VLD/VST, plus one cycle per MemRdy=0 stall.
// Backpressure: RD/WR and Addr are held until MemRdy=1. MemRdy is ignored while no request is open.
module cvp_seq #(
    parameter int          LANES    = 16,
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter int          LW       = $clog2(LANES)
) (
    input  logic          Clk1,
    input  logic          Reset,
    output logic [15:0]   Addr,
    output logic          RD,
    output logic          WR,
    output logic [15:0]   DataOut,
    input  logic [15:0]   DataIn,
    input  logic          MemRdy,
    output logic          Illegal,
    input  logic [2:0]    DbgSSel,
    output logic [15:0]   DbgSData,
    input  logic [2:0]    DbgVSel,
    input  logic [LW-1:0] DbgLane,
    output logic [15:0]   DbgVData
`ifdef SINGLE_STEP_EN
    ,
    input  logic          Step,
    output logic          Halted
`endif
);

    localparam logic [3:0] OP_VLD = 4'b0100;
    localparam logic [3:0] OP_VST = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SLH = 4'b0111;
    localparam logic [3:0] OP_J   = 4'b1000;
    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_DONE
`ifdef SINGLE_STEP_EN
        ,
        S_HALT
`endif
    } state_t;

    state_t        state_q;
    logic [15:0]   pc_q;
    logic [15:0]   ir_q;
    logic [LW-1:0] lane_q;
    logic [15:0]   addr_q;
    logic          rd_q;
    logic          wr_q;
    logic [15:0]   dout_q;
    logic          illegal_q;
`ifdef SINGLE_STEP_EN
    logic          halted_q;
`endif

    logic [15:0] s_q [8];
    logic [15:0] v_q [8][LANES];

    logic [3:0]    op;
    logic [2:0]    rd_f;
    logic [2:0]    rs_f;
    logic [15:0]   base;
    logic [LW-1:0] lane_d;
    logic          last_lane;
    logic [15:0]   pc_d;

    assign op        = ir_q[15:12];
    assign rd_f      = ir_q[11:9];
    assign rs_f      = ir_q[8:6];
    assign base      = s_q[rs_f] + {10'b0, ir_q[5:0]};
    assign lane_d    = lane_q + 1'b1;
    assign last_lane = (lane_q == LW'(LANES - 1));
    assign pc_d      = (op == OP_J) ? {pc_q[15:12], ir_q[11:0]} : pc_q + 16'd1;

    assign Addr     = addr_q;
    assign RD       = rd_q;
    assign WR       = wr_q;
    assign DataOut  = dout_q;
    assign Illegal  = illegal_q;
    assign DbgSData = s_q[DbgSSel];
    assign DbgVData = v_q[DbgVSel][DbgLane];
`ifdef SINGLE_STEP_EN
    assign Halted   = halted_q;
`endif

    // Register files carry no reset; a reset edge blocks any write so a cut-short VLD keeps only completed lanes.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            if (state_q == S_DECODE && op == OP_SLL) s_q[rd_f][7:0]  <= ir_q[7:0];
            if (state_q == S_DECODE && op == OP_SLH) s_q[rd_f][15:8] <= ir_q[7:0];
            if (state_q == S_EXEC && op == OP_VLD && rd_q && MemRdy)
                v_q[rd_f][lane_q] <= DataIn;
        end
    end

    always_ff @(posedge Clk1) begin
        if (!Reset) begin
            state_q   <= S_START;
            pc_q      <= PC_RESET;
            ir_q      <= 16'h0000;
            lane_q    <= '0;
            addr_q    <= 16'h0000;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            dout_q    <= 16'h0000;
            illegal_q <= 1'b0;
`ifdef SINGLE_STEP_EN
            halted_q  <= 1'b0;
`endif
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                S_START: begin
                    addr_q  <= pc_q;
                    rd_q    <= 1'b1;
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (MemRdy) begin
                        ir_q    <= DataIn;
                        rd_q    <= 1'b0;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    lane_q <= '0;
                    if (op == OP_VLD || op == OP_VST) begin
                        addr_q  <= base;
                        rd_q    <= (op == OP_VLD);
                        wr_q    <= (op == OP_VST);
                        dout_q  <= v_q[rd_f][0];
                        state_q <= S_EXEC;
                    end else begin
                        illegal_q <= !(op inside {OP_SLL, OP_SLH, OP_J, OP_NOP});
                        state_q   <= S_DONE;
                    end
                end
                S_EXEC: begin
                    if (MemRdy) begin
                        lane_q <= lane_d;
                        if (last_lane) begin
                            rd_q    <= 1'b0;
                            wr_q    <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            addr_q <= base + 16'(lane_d);
                            dout_q <= v_q[rd_f][lane_d];
                        end
                    end
                end
                S_DONE: begin
                    pc_q <= pc_d;
`ifdef SINGLE_STEP_EN
                    halted_q <= 1'b1;
                    state_q  <= S_HALT;
`else
                    addr_q  <= pc_d;
                    rd_q    <= 1'b1;
                    state_q <= S_FETCH;
`endif
                end
`ifdef SINGLE_STEP_EN
                S_HALT: begin
                    if (Step) begin
                        halted_q <= 1'b0;
                        addr_q   <= pc_q;
                        rd_q     <= 1'b1;
                        state_q  <= S_FETCH;
                    end
                end
`endif
                default: state_q <= S_START;
            endcase
        end
    end

endmodule
